fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Two-producer write arbiter for a single FIFO write port.
// Bursts of up to BURST_LEN words per grant, with a round-robin pointer between bursts.
module fifo_wr_arb #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [FIFO_WIDTH-1:0] data0,
  input  logic [FIFO_WIDTH-1:0] data1,
  input  logic                  full,
  input  logic                  almostfull,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t                state;
  logic                  prio;
  logic [3:0]            beat_cnt;

  logic                  serving;
  logic                  serving1;
  logic                  req_cur;
  logic                  req_oth;
  logic [FIFO_WIDTH-1:0] data_cur;
  logic                  accept;
  logic [3:0]            beat_nxt;
  logic                  last_beat;

  // A write still in flight while the FIFO sits at DEPTH-1 fills it, so it blocks this accept.
  always_comb begin
    serving   = (state == SERVE0) || (state == SERVE1);
    serving1  = (state == SERVE1);
    req_cur   = serving1 ? req1 : req0;
    req_oth   = serving1 ? req0 : req1;
    data_cur  = serving1 ? data1 : data0;
    accept    = serving && req_cur && !full && !(wr_en && almostfull);
    beat_nxt  = beat_cnt + 4'd1;
    last_beat = accept && (beat_nxt == BURST_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= 4'd0;
      wr_en    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      data_in  <= '0;
    end else begin
      wr_en <= accept;
      gnt0  <= accept && !serving1;
      gnt1  <= accept && serving1;
      if (accept) begin
        data_in <= data_cur;
      end

      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= prio ? SERVE1 : SERVE0;
          end else if (req0) begin
            state <= SERVE0;
          end else if (req1) begin
            state <= SERVE1;
          end
        end
        SERVE0, SERVE1: begin
          // On exit the other producer gets priority; a lone requester restarts its burst.
          if (!req_cur || last_beat) begin
            prio     <= !serving1;
            beat_cnt <= 4'd0;
            if (req_oth) begin
              state <= serving1 ? SERVE0 : SERVE1;
            end else if (!req_cur) begin
              state <= IDLE;
            end
          end else if (accept) begin
            beat_cnt <= beat_nxt;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
